sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; array depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter TIMER_ADDR, default 32'hBFAF_E000, byte address of the memory-mapped timer register.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sram_en  input  1  access request this cycle.
REQ-006 sram_wen  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i]; 4'b0000 with en=1 is a read.
REQ-007 sram_addr  input  32  byte address; bits [1:0] ignored; word index is sram_addr[ADDR_W+1:2].
REQ-008 sram_wdata  input  32  write data.
REQ-009 sram_rdata  output  32  registered read data.
REQ-010 ready  output  1  responder accepting accesses.

Function
REQ-011 The block is the responder for the core's SRAM-style port: no handshake back-pressure; every accepted request completes in fixed time.
REQ-012 An access is accepted in cycle N iff sram_en=1 and ready=1; otherwise it has no effect.
REQ-013 Read (wen=0): sram_rdata shows the addressed word from cycle N+1 and holds it until the next accepted read.
REQ-014 Write (wen!=0): only enabled byte lanes of the addressed word are updated at the end of cycle N; sram_rdata unchanged.
REQ-015 Write in cycle N followed by a read of the same word in N+1: the read returns the newly written bytes (no stale data).
REQ-016 Address decode: sram_addr equal to TIMER_ADDR (bits [31:2] compared) selects the timer; any other address selects the array, upper bits above ADDR_W+1 ignored (aliasing).
REQ-017 Timer: 32-bit free-running counter, +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
REQ-018 Timer read in cycle N returns the counter value held during cycle N.
REQ-019 Timer write with wen=4'hF in cycle N loads wdata; counter equals wdata in N+1 and increments from there; partial-lane timer writes are ignored (counter keeps incrementing).
REQ-020 Timer accesses never modify the array.

Reset
REQ-021 On rst=1 at a clock edge: sram_rdata=0, timer=0.
REQ-022 Reset asserted mid-operation aborts any in-progress clear and restarts it per REQ-024; array contents are otherwise not reset.
REQ-023 Without SRAM_CLEAR_EN, ready=1 from the first cycle after reset.

Configuration
REQ-024 Macro SRAM_CLEAR_EN defined: FSM states CLEAR, READY; reset enters CLEAR with index 0; each CLEAR cycle writes 0 to word[index] and increments index; after writing index 2^ADDR_W-1 the FSM moves to READY; ready=1 only in READY (first ready cycle is cycle 2^ADDR_W after reset deasserts).
REQ-025 With SRAM_CLEAR_EN, requests during CLEAR are ignored, sram_rdata stays 0, timer still counts.
REQ-026 SRAM_CLEAR_EN undefined: no FSM or index counter, ready is constant 1 after reset, array power-up contents undefined.

Verification
REQ-027 Write addr 0x10 wdata 0xDEADBEEF wen 4'hF, read 0x10 next cycle -> rdata 0xDEADBEEF in following cycle.
REQ-028 After REQ-027, write 0x10 wdata 0x11223344 wen 4'b0101, read -> rdata 0xDE22BE44.
REQ-029 Read TIMER_ADDR in cycle 5 after reset -> rdata 5; write 0xFFFF_FFFE wen 4'hF, read two cycles later -> 0xFFFF_FFFF, read next -> 0x0000_0000 (wrap).
REQ-030 Timer write wen 4'b0001 wdata 0 -> ignored, subsequent read shows uninterrupted count.
REQ-031 ADDR_W=4: write 0x04 value 0xA5A5A5A5, read 0x44 -> 0xA5A5A5A5 (alias); read after a write keeps rdata at last read value during the write cycle.
REQ-032 SRAM_CLEAR_EN, ADDR_W=4: ready low cycles 0-15, high at 16; write issued in cycle 3 ignored; reassert rst at cycle 8 -> ready low for 16 further cycles; all words read 0.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: fixed-latency SRAM-port responder with a memory-mapped free-running timer; define SRAM_CLEAR_EN to zero-fill the array after reset
module sram_responder #(
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] TIMER_ADDR = 32'hBFAF_E000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        ready
);
    localparam int DEPTH = 1 << ADDR_W;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       rdata_q, rdata_d, timer_q, timer_d;
    logic [ADDR_W-1:0] widx, clr_idx;
    logic              acc, is_timer, clr_we, unused_addr;
    assign widx        = sram_addr[ADDR_W+1:2];
    assign is_timer    = sram_addr[31:2] == TIMER_ADDR[31:2];
    assign acc         = sram_en & ready;
    assign unused_addr = ^sram_addr[1:0];
    assign sram_rdata  = rdata_q;
`ifdef SRAM_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    assign clr_we  = state_q == CLEAR;
    assign clr_idx = idx_q;
    assign ready   = state_q == READY;
    // Sweep state and index; reset always restarts the sweep from word 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
    // Step through every word, then open the port after the last one
    always_comb begin
        state_d = (state_q == CLEAR && &idx_q) ? READY : state_q;
        idx_d   = (state_q == CLEAR) ? idx_q + 1'b1 : idx_q;
    end
`else
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
    assign ready   = 1'b1;
`endif
    // Array write port: clear sweep or byte-lane write; timer hits never touch the array
    always_ff @(posedge clk) begin
        if (clr_we)
            mem_q[clr_idx] <= '0;
        else if (acc && !is_timer)
            for (int i = 0; i < 4; i++)
                if (sram_wen[i]) mem_q[widx][8*i +: 8] <= sram_wdata[8*i +: 8];
    end
    // Timer loads only on a full-word write; read data updates only on an accepted read
    always_comb begin
        timer_d = (acc && is_timer && sram_wen == 4'hF) ? sram_wdata : timer_q + 32'd1;
        rdata_d = (acc && sram_wen == 4'h0) ? (is_timer ? timer_q : mem_q[widx]) : rdata_q;
    end
    // Registered read data and timer
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            timer_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            timer_q <= timer_d;
        end
    end
endmodule
